ftdi_tx_arbiter: RTL and testbench
==================================

Name: ftdi_tx_arbiter

Overview:
- Shares the host-bound byte path (write side of the FTDI write FIFO, `clk` domain) between N_SRC packet producers, e.g. the RFG read-response path and streaming/event sources.
- Frames each packet as: header byte, 16-bit length (MSB first), then payload.
- Grants the FIFO to one source per packet. Arbitration is round-robin at packet boundaries.
- Sits between the producers and the FIFO write port (`wi_wr`/`wi_data`/`wi_almost_full`).

Parameters:
- N_SRC, 2, number of requesters (1..16).
- HDR_MARK, 4'hA, upper nibble of every header byte.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- src_req  in  N_SRC  per-source packet request; level, held until granted
- src_len  in  16*N_SRC  payload length in bytes; source i occupies bits [16i+15:16i]; sampled at grant
- src_data  in  8*N_SRC  payload byte of source i
- src_valid  in  N_SRC  src_data valid
- src_ready  out  N_SRC  byte accepted when src_valid & src_ready
- src_grant  out  N_SRC  one-hot; high for the whole packet of the granted source
- wi_wr  out  1  FIFO write strobe, one byte per cycle
- wi_data  out  8  FIFO write data
- wi_almost_full  in  1  FIFO almost-full; stalls issuing
- busy  out  1  high when state != IDLE

Behaviour:
- Reset (synchronous): state IDLE, src_grant=0, src_ready=0, wi_wr=0, wi_data=0, busy=0, rr pointer=0, byte counter=0.
- wi_wr and wi_data are registered. A byte issued in cycle t appears with wi_wr=1 in t+1.
- A byte is issued only in cycles where wi_almost_full=0. The FIFO's almost-full margin absorbs the one in-flight byte. When nothing is issued, wi_wr=0 in the next cycle.
- FSM states: IDLE, HDR, LEN_H, LEN_L, PAYLOAD.
- IDLE:
  - If any src_req is set, pick the first requester searching from rr pointer upward, wrapping modulo N_SRC.
  - Register cur_src and len=src_len[cur_src]. Set src_grant[cur_src]. Go to HDR.
  - Grant is registered, so src_grant rises one cycle after src_req is seen.
- HDR: when not stalled, issue byte {HDR_MARK, cur_src[3:0]}; go to LEN_H.
- LEN_H: when not stalled, issue len[15:8]; go to LEN_L.
- LEN_L: when not stalled, issue len[7:0].
  - If len==0: go to IDLE and release the grant.
  - Otherwise: counter=len; go to PAYLOAD.
- PAYLOAD:
  - src_ready[cur_src] = (state==PAYLOAD) & ~wi_almost_full. This is combinational from state and almost_full. src_ready of all other sources = 0.
  - On each src_valid & src_ready: issue src_data[cur_src] and decrement counter.
  - The transfer that takes counter from 1 to 0 moves the FSM to IDLE, clears src_grant, and sets rr pointer = cur_src+1 (wrap to 0 at N_SRC).
  - A src_valid gap inserts no byte; wi_wr=0 in the following cycle.
- Arbitration happens only in IDLE. A grant is never revoked mid-packet. src_req deasserting during a packet is ignored.
- The IDLE cycle after each packet costs one bubble. Minimum packet spacing is therefore len+4 cycles.
- Requests arriving in the same cycle are resolved by the rr order only; the rr pointer is not updated on grant, only on packet completion.
- The length field is frozen at grant. Later src_len changes do not affect the packet in progress.
- Reset mid-packet: aborts immediately. Next cycle all outputs are at reset values; a partial packet may remain in the FIFO (the host resynchronises on HDR_MARK).
- wi_almost_full asserted in any state: the FSM holds state, counter and grant; no byte is issued.

Test Plan:
- Single source 0, len=3, data 11,22,33, FIFO never full -> wi_data sequence A0,00,03,11,22,33 on 6 consecutive wi_wr cycles; src_grant[0] released after 33; busy returns to 0.
- Sources 0 and 1 both request continuously, len=1 each -> headers alternate A0,A1,A0,A1; no source is granted twice in a row.
- len=0 from source 1 -> exactly A1,00,00 written; src_ready never asserted; FSM back in IDLE one cycle after the last issue.
- wi_almost_full held high for 5 cycles mid-payload of a len=4 packet -> no wi_wr during the stall plus one cycle; src_ready=0 during the stall; all 4 payload bytes delivered in order, none lost or duplicated.
- src_valid toggles 1,0,1,0 during a len=2 payload -> exactly 2 payload writes with a gap; src_req drop mid-packet does not end the packet.
- rst asserted during the PAYLOAD of a len=10 packet -> next cycle wi_wr=0, src_grant=0, busy=0; a fresh request after reset starts with a new header byte.

Source files
------------

// File: rtl/ftdi_tx_arbiter.sv
// Round-robin packet arbiter in front of the FTDI write FIFO.
// Each granted packet is framed as {HDR_MARK, src}, len[15:8], len[7:0], payload.
module ftdi_tx_arbiter #(
  parameter int         N_SRC    = 2,
  parameter logic [3:0] HDR_MARK = 4'hA
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SRC-1:0]     src_req,
  input  logic [16*N_SRC-1:0]  src_len,
  input  logic [8*N_SRC-1:0]   src_data,
  input  logic [N_SRC-1:0]     src_valid,
  output logic [N_SRC-1:0]     src_ready,
  output logic [N_SRC-1:0]     src_grant,
  output logic                 wi_wr,
  output logic [7:0]           wi_data,
  input  logic                 wi_almost_full,
  output logic                 busy
);

  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LEN_H,
    LEN_L,
    PAYLOAD
  } state_t;

  state_t           state, state_d;
  logic [SW-1:0]    cur_src, cur_src_d;
  logic [SW-1:0]    rr_ptr, rr_ptr_d;
  logic [15:0]      len, len_d;
  logic [15:0]      cnt, cnt_d;
  logic [N_SRC-1:0] grant_d;
  logic             wr_d;
  logic [7:0]       data_d;

  logic [SW-1:0]    pick;
  logic [SW-1:0]    next_rr;
  logic [15:0]      pick_len;
  logic [7:0]       cur_data;
  logic [3:0]       hdr_src;
  logic             take;

  // First requester at or above start, wrapping modulo N_SRC.
  function automatic logic [SW-1:0] rr_pick(input logic [N_SRC-1:0] req,
                                            input logic [SW-1:0]    start);
    logic [SW-1:0] sel;
    logic          found;
    sel   = start;
    found = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      int idx;
      idx = int'(start) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!found && req[idx]) begin
        sel   = SW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign pick     = rr_pick(src_req, rr_ptr);
  assign pick_len = src_len[16*int'(pick) +: 16];
  assign cur_data = src_data[8*int'(cur_src) +: 8];
  assign hdr_src  = 4'(cur_src);
  assign next_rr  = (cur_src == SW'(N_SRC - 1)) ? '0 : SW'(cur_src + 1'b1);
  assign busy     = (state != IDLE);
  assign take     = src_valid[cur_src] & src_ready[cur_src];

  always_comb begin
    src_ready = '0;
    if (state == PAYLOAD && !wi_almost_full) src_ready[cur_src] = 1'b1;
  end

  always_comb begin
    // NOTE: every signal gets a default here so no path through the case infers a latch.
    state_d   = state;
    cur_src_d = cur_src;
    rr_ptr_d  = rr_ptr;
    len_d     = len;
    cnt_d     = cnt;
    grant_d   = src_grant;
    wr_d      = 1'b0;
    data_d    = wi_data;

    case (state)
      // Almost-full freezes the FSM everywhere, including the grant decision.
      IDLE: begin
        if (|src_req && !wi_almost_full) begin
          cur_src_d     = pick;
          len_d         = pick_len;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          state_d       = HDR;
        end
      end

      HDR: begin
        if (!wi_almost_full) begin
          wr_d    = 1'b1;
          data_d  = {HDR_MARK, hdr_src};
          state_d = LEN_H;
        end
      end

      LEN_H: begin
        if (!wi_almost_full) begin
          wr_d    = 1'b1;
          data_d  = len[15:8];
          state_d = LEN_L;
        end
      end

      LEN_L: begin
        if (!wi_almost_full) begin
          wr_d   = 1'b1;
          data_d = len[7:0];
          if (len == 16'd0) begin
            grant_d  = '0;
            rr_ptr_d = next_rr;
            state_d  = IDLE;
          end else begin
            cnt_d   = len;
            state_d = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        if (take) begin
          wr_d   = 1'b1;
          data_d = cur_data;
          cnt_d  = cnt - 16'd1;
          if (cnt == 16'd1) begin
            grant_d  = '0;
            rr_ptr_d = next_rr;
            state_d  = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state is only ever updated with non-blocking assignments.
    if (rst) begin
      state     <= IDLE;
      cur_src   <= '0;
      rr_ptr    <= '0;
      len       <= '0;
      cnt       <= '0;
      src_grant <= '0;
      wi_wr     <= 1'b0;
      wi_data   <= '0;
    end else begin
      state     <= state_d;
      cur_src   <= cur_src_d;
      rr_ptr    <= rr_ptr_d;
      len       <= len_d;
      cnt       <= cnt_d;
      src_grant <= grant_d;
      wi_wr     <= wr_d;
      wi_data   <= data_d;
    end
  end

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// Self-checking bench for ftdi_tx_arbiter: queued source packets, a round-robin
// stream model, and per-scenario timing checks.
module tb_ftdi_tx_arbiter;

  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   src_req, src_valid, src_ready, src_grant;
  logic [16*N-1:0] src_len;
  logic [8*N-1:0] src_data;
  logic           wi_wr, wi_almost_full, busy;
  logic [7:0]     wi_data;

  always #5 clk = ~clk;

  ftdi_tx_arbiter #(.N_SRC(N), .HDR_MARK(4'hA)) dut (
    .clk(clk), .rst(rst),
    .src_req(src_req), .src_len(src_len), .src_data(src_data),
    .src_valid(src_valid), .src_ready(src_ready), .src_grant(src_grant),
    .wi_wr(wi_wr), .wi_data(wi_data), .wi_almost_full(wi_almost_full),
    .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int grise = -1;
  int m_rr  = 0;
  bit ready_seen;

  logic [15:0]  lq [N][$];
  logic [7:0]   sq [N][$];
  logic [7:0]   got[$], exp_q[$];
  int           got_t[$];
  logic         got_busy[$];
  logic [N-1:0] got_gnt[$];
  int           gorder[$], exp_order[$];
  logic [N-1:0] prev_grant = '0;

  task automatic drive(input logic af, input logic [N-1:0] ven);
    wi_almost_full = af;
    for (int i = 0; i < N; i++) begin
      src_req[i]          = (lq[i].size() != 0);
      src_len[16*i +: 16] = (lq[i].size() != 0) ? lq[i][0] : 16'h0;
      src_data[8*i +: 8]  = (sq[i].size() != 0) ? sq[i][0] : 8'h0;
      src_valid[i]        = ven[i] && (sq[i].size() != 0);
    end
  endtask

  // One clock: drive inputs, qualify src_ready, clock, then sample outputs.
  task automatic step(input logic af, input logic [N-1:0] ven);
    logic [N-1:0] acc, allow;
    drive(af, ven);
    #1;
    acc   = src_valid & src_ready;
    allow = af ? {N{1'b0}} : src_grant;
    if (src_ready != '0) ready_seen = 1'b1;
    total++;
    if ((src_ready & ~allow) !== '0) begin
      bad++;
      $display("FAIL ready_qual: src_ready=%b grant=%b af=%b", src_ready, src_grant, af);
    end
    @(posedge clk);
    #1;
    cyc++;
    total++;
    if ($countones(src_grant) > 1) begin
      bad++;
      $display("FAIL grant_onehot: src_grant=%b", src_grant);
    end
    if (wi_wr === 1'b1) begin
      got.push_back(wi_data);
      got_t.push_back(cyc);
      got_busy.push_back(busy);
      got_gnt.push_back(src_grant);
      total++;
      if (af) begin
        bad++;
        $display("FAIL wr_while_full: wi_wr=1 data=%h after almost_full cycle", wi_data);
      end
    end
    for (int i = 0; i < N; i++)
      if (acc[i]) void'(sq[i].pop_front());
    for (int i = 0; i < N; i++)
      if (src_grant[i] && !prev_grant[i]) begin
        gorder.push_back(i);
        grise = cyc;
        if (lq[i].size() != 0) void'(lq[i].pop_front());
      end
    prev_grant = src_grant;
  endtask

  task automatic clear_log();
    got.delete(); got_t.delete(); got_busy.delete(); got_gnt.delete();
    gorder.delete(); exp_q.delete(); exp_order.delete();
    grise      = -1;
    ready_seen = 1'b0;
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      lq[i].delete();
      sq[i].delete();
    end
  endtask

  task automatic do_reset();
    clear_queues();
    rst = 1'b1;
    step(1'b0, '0);
    step(1'b0, '0);
    rst  = 1'b0;
    m_rr = 0;
    clear_log();
  endtask

  task automatic add_pkt(input int s, input logic [15:0] len,
                         input logic [7:0] first, input logic [7:0] inc);
    logic [7:0] b;
    b = first;
    lq[s].push_back(len);
    for (int k = 0; k < int'(len); k++) begin
      sq[s].push_back(b);
      b = b + inc;
    end
  endtask

  // Reference: packets leave in round-robin order among sources with work left.
  function automatic void build_model();
    int rem[N];
    int pl[N];
    int pd[N];
    int s;
    logic [15:0] l;
    exp_q.delete();
    exp_order.delete();
    for (int i = 0; i < N; i++) begin
      rem[i] = lq[i].size();
      pl[i]  = 0;
      pd[i]  = 0;
    end
    for (int p = 0; p < 1000; p++) begin
      s = -1;
      for (int k = 0; k < N; k++)
        if (s < 0 && rem[(m_rr + k) % N] > 0) s = (m_rr + k) % N;
      if (s < 0) break;
      l = lq[s][pl[s]];
      exp_q.push_back(8'hA0 | 8'(s));
      exp_q.push_back(l[15:8]);
      exp_q.push_back(l[7:0]);
      for (int b = 0; b < int'(l); b++) begin
        exp_q.push_back(sq[s][pd[s]]);
        pd[s]++;
      end
      pl[s]++;
      rem[s]--;
      exp_order.push_back(s);
      m_rr = (s + 1) % N;
    end
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++)
      if (lq[i].size() != 0 || sq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_until_done(input int budget, input int af_pct, input int val_pct);
    int n;
    logic [N-1:0] ven;
    n = 0;
    while (!(all_empty() && busy === 1'b0) && n < budget) begin
      for (int i = 0; i < N; i++) ven[i] = ($urandom_range(99) < val_pct);
      step($urandom_range(99) < af_pct, ven);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL timeout: packets not drained after %0d cycles", n);
    end
  endtask

  task automatic check_stream(input string name);
    int m;
    total++;
    if (got.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s_len: got %0d bytes expected %0d", name, got.size(), exp_q.size());
    end
    m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int k = 0; k < m; k++) begin
      total++;
      if (got[k] !== exp_q[k]) begin
        bad++;
        $display("FAIL %s_byte%0d: got %h expected %h", name, k, got[k], exp_q[k]);
      end
    end
    total++;
    if (gorder.size() != exp_order.size()) begin
      bad++;
      $display("FAIL %s_ngrant: got %0d grants expected %0d", name, gorder.size(), exp_order.size());
    end else begin
      for (int k = 0; k < gorder.size(); k++) begin
        total++;
        if (gorder[k] != exp_order[k]) begin
          bad++;
          $display("FAIL %s_order%0d: got src %0d expected %0d", name, k, gorder[k], exp_order[k]);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total += 5;
    if (wi_wr !== 1'b0)   begin bad++; $display("FAIL rst_wr: got %b expected 0", wi_wr); end
    if (wi_data !== 8'h0) begin bad++; $display("FAIL rst_data: got %h expected 00", wi_data); end
    if (src_grant !== '0) begin bad++; $display("FAIL rst_grant: got %b expected 0", src_grant); end
    if (src_ready !== '0) begin bad++; $display("FAIL rst_ready: got %b expected 0", src_ready); end
    if (busy !== 1'b0)    begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    int start;
    do_reset();
    add_pkt(0, 16'd3, 8'h11, 8'h11);
    build_model();
    start = cyc;
    run_until_done(200, 0, 100);
    check_stream("single");
    total++;
    if (grise != start + 1) begin
      bad++; $display("FAIL single_grant_lat: grant at cycle %0d expected %0d", grise, start + 1);
    end
    if (got.size() == 6) begin
      total += 3;
      if (got_t[0] != grise + 1) begin
        bad++; $display("FAIL single_hdr_lat: header at %0d expected %0d", got_t[0], grise + 1);
      end
      if (got_t[5] - got_t[0] != 5) begin
        bad++; $display("FAIL single_back2back: span %0d expected 5", got_t[5] - got_t[0]);
      end
      if (got_gnt[5] !== '0 || got_busy[5] !== 1'b0) begin
        bad++; $display("FAIL single_release: grant=%b busy=%b expected 0,0", got_gnt[5], got_busy[5]);
      end
    end
  endtask

  task automatic test_alternate();
    logic [7:0] he[4];
    he = '{8'hA0, 8'hA1, 8'hA0, 8'hA1};
    do_reset();
    add_pkt(0, 16'd1, 8'h01, 8'h01);
    add_pkt(0, 16'd1, 8'h02, 8'h01);
    add_pkt(1, 16'd1, 8'hB1, 8'h01);
    add_pkt(1, 16'd1, 8'hB2, 8'h01);
    build_model();
    run_until_done(300, 0, 100);
    check_stream("alt");
    if (got.size() == 16) begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (got[4*k] !== he[k]) begin
          bad++; $display("FAIL alt_hdr%0d: got %h expected %h", k, got[4*k], he[k]);
        end
      end
      total++;
      if (got_t[4] - got_t[0] != 5) begin
        bad++; $display("FAIL alt_spacing: got %0d expected 5", got_t[4] - got_t[0]);
      end
    end
    for (int k = 1; k < gorder.size(); k++) begin
      total++;
      if (gorder[k] == gorder[k-1]) begin
        bad++; $display("FAIL alt_repeat%0d: src %0d granted twice in a row", k, gorder[k]);
      end
    end
  endtask

  task automatic test_len_zero();
    do_reset();
    add_pkt(1, 16'd0, 8'h00, 8'h00);
    build_model();
    run_until_done(100, 0, 100);
    check_stream("zero");
    total++;
    if (ready_seen) begin bad++; $display("FAIL zero_ready: src_ready asserted, expected never"); end
    if (got.size() == 3) begin
      total++;
      if (got_busy[2] !== 1'b0 || got_gnt[2] !== '0) begin
        bad++; $display("FAIL zero_idle: busy=%b grant=%b expected 0,0", got_busy[2], got_gnt[2]);
      end
    end
  endtask

  task automatic test_stall();
    int n, wr_during;
    bit stalled;
    do_reset();
    add_pkt(0, 16'd4, 8'h40, 8'h01);
    build_model();
    stalled   = 1'b0;
    wr_during = 0;
    n = 0;
    while (!(all_empty() && busy === 1'b0) && n < 200) begin
      if (!stalled && sq[0].size() == 2) begin
        for (int s = 0; s < 5; s++) begin
          step(1'b1, '1);
          if (wi_wr === 1'b1) wr_during++;
          total++;
          if (src_ready !== '0) begin
            bad++; $display("FAIL stall_ready%0d: got %b expected 0", s, src_ready);
          end
        end
        stalled = 1'b1;
      end else begin
        step(1'b0, '1);
      end
      n++;
    end
    total += 2;
    if (!stalled) begin bad++; $display("FAIL stall_reached: got 0 expected 1"); end
    if (wr_during != 0) begin
      bad++; $display("FAIL stall_wr: got %0d writes expected 0", wr_during);
    end
    check_stream("stall");
  endtask

  task automatic test_valid_gap();
    int n;
    logic [N-1:0] ven;
    do_reset();
    add_pkt(0, 16'd2, 8'h5A, 8'h11);
    build_model();
    n = 0;
    while (!(all_empty() && busy === 1'b0) && n < 100) begin
      ven = (grise >= 0 && ((cyc + 1 - grise) % 2 == 0)) ? '1 : '0;
      step(1'b0, ven);
      n++;
    end
    check_stream("gap");
    if (got.size() == 5) begin
      total++;
      if (got_t[4] - got_t[3] != 2) begin
        bad++; $display("FAIL gap_spacing: got %0d expected 2", got_t[4] - got_t[3]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    add_pkt(0, 16'd10, 8'h80, 8'h01);
    n = 0;
    while (sq[0].size() > 7 && n < 100) begin
      step(1'b0, '1);
      n++;
    end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL rmid_inpkt: busy=%b expected 1", busy); end
    rst = 1'b1;
    step(1'b0, '1);
    total += 3;
    if (wi_wr !== 1'b0)   begin bad++; $display("FAIL rmid_wr: got %b expected 0", wi_wr); end
    if (src_grant !== '0) begin bad++; $display("FAIL rmid_grant: got %b expected 0", src_grant); end
    if (busy !== 1'b0)    begin bad++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    rst  = 1'b0;
    m_rr = 0;
    clear_queues();
    clear_log();
    add_pkt(1, 16'd2, 8'hC0, 8'h01);
    build_model();
    run_until_done(100, 0, 100);
    check_stream("rmid");
    total++;
    if (got.size() == 0 || got[0] !== 8'hA1) begin
      bad++; $display("FAIL rmid_hdr: got %h expected a1", (got.size() != 0) ? got[0] : 8'hxx);
    end
  endtask

  task automatic test_random();
    int np;
    logic [15:0] l;
    do_reset();
    for (int s = 0; s < N; s++) begin
      np = $urandom_range(5, 3);
      for (int p = 0; p < np; p++) begin
        l = ($urandom_range(3) == 0) ? 16'd0 : 16'($urandom_range(8, 1));
        lq[s].push_back(l);
        for (int b = 0; b < int'(l); b++) sq[s].push_back(8'($urandom));
      end
    end
    build_model();
    run_until_done(4000, 25, 70);
    check_stream("rand");
  endtask

  initial begin
    rst            = 1'b1;
    src_req        = '0;
    src_len        = '0;
    src_data       = '0;
    src_valid      = '0;
    wi_almost_full = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_alternate();
    test_len_zero();
    test_stall();
    test_valid_gap();
    test_reset_mid();
    test_random();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
